// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package seq_mul_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_piso.sv
// Parallel-load, right-shift register; exposes the bit to be consumed next.
module mul_piso #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] d,
    output logic         q0
);

    logic [N-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset)
            sr <= '0;
        else if (load)
            sr <= d;
        else if (shift)
            sr <= {1'b0, sr[N-1:1]};
    end

    assign q0 = sr[0];

endmodule

// File: rtl/seq_mul.sv
// Sequential N x N multiplier, one multiplier bit per cycle, LSB first.
// Signed mode subtracts the weight of the multiplier's sign bit on the last step.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           sgn,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] y,
    output logic           ser_bit
);

    localparam int KW = $clog2(N + 1);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t         state;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] bext;
    logic [2*N-1:0] addend;
    logic [2*N-1:0] acc_next;
    logic [KW-1:0]  k;
    logic           sgn_q;
    logic           q0;
    logic           load;
    logic           shift;

    assign load  = (state == IDLE) && start;
    assign shift = (state == RUN);

    mul_piso #(.N(N)) u_piso (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .d     (a),
        .q0    (q0)
    );

    assign ser_bit = shift & q0;

    always_comb begin
        addend   = bext << k;
        acc_next = acc;
        if (q0)
            acc_next = (sgn_q && (k == K_LAST)) ? acc - addend : acc + addend;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            bext  <= '0;
            k     <= '0;
            sgn_q <= 1'b0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        bext  <= sgn ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
                        sgn_q <= sgn;
                        acc   <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    // Product is final after the last step, so publish it on entry to DONE.
                    if (k == K_LAST) begin
                        state <= DONE;
                        y     <= acc_next;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
